// File: rtl/motor_sequencer.sv
// Dual H-bridge sequencer: every change of drive command passes through a
// coast (all-zero) dead interval before the new bridge pattern is applied.
module motor_sequencer #(
   parameter int DEAD_CYCLES = 25_000,
   parameter int PWM_PERIOD  = 1_000,
   parameter int HALF_DUTY   = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] dir_cmd,
   input  logic       estop,
   output logic       l_in1,
   output logic       l_in2,
   output logic       r_in1,
   output logic       r_in2,
   output logic       busy,
   output logic [1:0] state
);

   localparam int DW = $clog2(DEAD_CYCLES + 1);
   localparam int PW = $clog2(PWM_PERIOD + 1);
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
   localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
   localparam logic [PW-1:0] HIGH_CYC  = PW'(HALF_DUTY);
   localparam logic [3:0]    CMD_STOP  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DEAD  = 2'b01,
      DRIVE = 2'b10,
      FAULT = 2'b11
   } state_t;

   state_t        st;
   logic [3:0]    cmd_q;
   logic [3:0]    act_cmd;
   logic [DW-1:0] dead_cnt;
   logic [PW-1:0] pwm_cnt;
   logic          pwm;

   assign state = st;
   assign pwm   = (pwm_cnt < HIGH_CYC);

   // {in1, in2} for one motor code
   function automatic logic [1:0] bridge_bits(input logic [1:0] code, input logic p);
      logic [1:0] b;
      case (code)
         2'b00:   b = 2'b10;
         2'b01:   b = {p, 1'b0};
         2'b10:   b = 2'b01;
         default: b = 2'b11;
      endcase
      return b;
   endfunction

   // Free-running so half-speed phase is unaffected by command changes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 pwm_cnt <= '0;
      else if (pwm_cnt == PWM_LAST) pwm_cnt <= '0;
      else                        pwm_cnt <= pwm_cnt + PW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cmd_q <= CMD_STOP;
      else        cmd_q <= dir_cmd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         act_cmd  <= CMD_STOP;
         dead_cnt <= '0;
         l_in1    <= 1'b0;
         l_in2    <= 1'b0;
         r_in1    <= 1'b0;
         r_in2    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         // Outputs default to coast; only the DRIVE paths below override them
         l_in1 <= 1'b0;
         l_in2 <= 1'b0;
         r_in1 <= 1'b0;
         r_in2 <= 1'b0;
         busy  <= 1'b0;
         if (estop) begin
            st <= FAULT;
         end else begin
            case (st)
               IDLE: begin
                  if (cmd_q != CMD_STOP) begin
                     st       <= DEAD;
                     act_cmd  <= cmd_q;
                     dead_cnt <= '0;
                     busy     <= 1'b1;
                  end
               end
               DEAD: begin
                  if (cmd_q != act_cmd) begin
                     act_cmd  <= cmd_q;
                     dead_cnt <= '0;
                     busy     <= 1'b1;
                  end else if (dead_cnt == DEAD_LAST) begin
                     st             <= DRIVE;
                     {l_in1, l_in2} <= bridge_bits(act_cmd[3:2], pwm);
                     {r_in1, r_in2} <= bridge_bits(act_cmd[1:0], pwm);
                  end else begin
                     dead_cnt <= dead_cnt + DW'(1);
                     busy     <= 1'b1;
                  end
               end
               DRIVE: begin
                  if (cmd_q != act_cmd) begin
                     st       <= DEAD;
                     act_cmd  <= cmd_q;
                     dead_cnt <= '0;
                     busy     <= 1'b1;
                  end else begin
                     {l_in1, l_in2} <= bridge_bits(act_cmd[3:2], pwm);
                     {r_in1, r_in2} <= bridge_bits(act_cmd[1:0], pwm);
                  end
               end
               FAULT: begin
                  if (cmd_q == CMD_STOP) st <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_motor_sequencer.sv
// Bench for motor_sequencer: directed vector table, hand sequences for the
// multi-cycle corners, then random commands against a behavioural model.
module tb_motor_sequencer;

   localparam int DC = 4;
   localparam int PP = 10;
   localparam int HD = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] dir_cmd;
   logic       estop;
   logic       l_in1, l_in2, r_in1, r_in2, busy;
   logic [1:0] state;

   always #5 clk = ~clk;

   motor_sequencer #(.DEAD_CYCLES(DC), .PWM_PERIOD(PP), .HALF_DUTY(HD)) dut (
      .clk(clk), .rst_n(rst_n), .dir_cmd(dir_cmd), .estop(estop),
      .l_in1(l_in1), .l_in2(l_in2), .r_in1(r_in1), .r_in2(r_in2),
      .busy(busy), .state(state)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [3:0] bridge();
      return {l_in1, l_in2, r_in1, r_in2};
   endfunction

   // Behavioural model: the sequencer is "armed" once a non-stop command is
   // seen; bridges are driven only when the latched command has been stable
   // for at least DC edges. PWM phase is the edge count since reset.
   int         m_tick, m_since;
   bit         m_armed, m_fault;
   logic [3:0] m_cq, m_act, m_br;
   logic [1:0] m_st;
   logic       m_bz;

   function automatic logic [1:0] dec(input logic [1:0] c, input bit p);
      case (c)
         2'b00:   return 2'b10;
         2'b01:   return {p, 1'b0};
         2'b10:   return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   task automatic model_reset();
      m_tick = 0; m_since = 0; m_armed = 0; m_fault = 0;
      m_cq = 4'hF; m_act = 4'hF; m_br = 4'h0; m_st = 2'd0; m_bz = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] din, input logic es);
      bit pwm, drive;
      pwm = (m_tick % PP) < HD;
      m_tick++;
      if (es) begin
         m_fault = 1; m_armed = 0;
      end else if (m_fault) begin
         if (m_cq == 4'hF) m_fault = 0;
      end else if (!m_armed) begin
         if (m_cq != 4'hF) begin m_armed = 1; m_act = m_cq; m_since = 0; end
      end else if (m_cq != m_act) begin
         m_act = m_cq; m_since = 0;
      end else if (m_since < DC) begin
         m_since++;
      end
      m_cq  = din;
      drive = m_armed && (m_since >= DC);
      m_st  = m_fault ? 2'd3 : (!m_armed ? 2'd0 : (drive ? 2'd2 : 2'd1));
      m_bz  = (m_st == 2'd1);
      m_br  = drive ? {dec(m_act[3:2], pwm), dec(m_act[1:0], pwm)} : 4'h0;
   endtask

   logic [1:0] pl, pr, pst;
   logic       pr1;
   int         last_fall;

   task automatic clear_hist();
      pl = 2'b00; pr = 2'b00; pst = 2'b00; pr1 = 1'b0;
   endtask

   // One clock: drive at negedge, sample 1 time unit after posedge, end at negedge
   task automatic cycle(input logic [3:0] d, input logic es);
      dir_cmd = d; estop = es;
      model_step(d, es);
      @(posedge clk); #1;
      cyc++;
      chk("state", int'(state), int'(m_st));
      chk("bridge", int'(bridge()), int'(m_br));
      chk("busy", int'(busy), int'(m_bz));
      chk("shoot_through_l", int'(pl != 2'b00 && {l_in1, l_in2} != 2'b00 && pl != {l_in1, l_in2}), 0);
      chk("shoot_through_r", int'(pr != 2'b00 && {r_in1, r_in2} != 2'b00 && pr != {r_in1, r_in2}), 0);
      if (pst == 2'b10 && state == 2'b10 && pr1 && !r_in1) last_fall = cyc;
      pl = {l_in1, l_in2}; pr = {r_in1, r_in2}; pst = state; pr1 = r_in1;
      @(negedge clk);
   endtask

   task automatic run_until(input logic [1:0] tgt, input logic [3:0] d, input int bound, input string nm);
      int n;
      n = 0;
      while (state != tgt && n < bound) begin
         cycle(d, 1'b0);
         n++;
      end
      chk(nm, int'(state), int'(tgt));
   endtask

   // Asynchronous reset pulse launched between edges; outputs must clear at once
   task automatic pulse_reset(input string nm);
      #2 rst_n = 1'b0;
      #1;
      chk({nm, "_state"}, int'(state), 0);
      chk({nm, "_bridge"}, int'(bridge()), 0);
      chk({nm, "_busy"}, int'(busy), 0);
      model_reset();
      clear_hist();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0] dir;
      logic       es;
      logic [1:0] st;
      logic [3:0] br;
      logic       bz;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [3:0] d, input logic es, input logic [1:0] st,
                      input logic [3:0] br, input logic bz);
      vec_t v;
      v.dir = d; v.es = es; v.st = st; v.br = br; v.bz = bz;
      vecs.push_back(v);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      int hi_l, hi_r, hi_2, fall_before, nd;
      rst_n = 1'b0; dir_cmd = 4'hF; estop = 1'b0;
      model_reset(); clear_hist(); last_fall = -1;
      #3;
      chk("reset_state", int'(state), 0);
      chk("reset_bridge", int'(bridge()), 0);
      chk("reset_busy", int'(busy), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // dir, estop -> state, {l_in1,l_in2,r_in1,r_in2}, busy
      add(4'hF, 0, 2'd0, 4'b0000, 0);
      add(4'h0, 0, 2'd0, 4'b0000, 0);
      add(4'h0, 0, 2'd1, 4'b0000, 1);
      add(4'h0, 0, 2'd1, 4'b0000, 1);
      add(4'h0, 0, 2'd1, 4'b0000, 1);
      add(4'h0, 0, 2'd1, 4'b0000, 1);
      add(4'h0, 0, 2'd2, 4'b1010, 0);
      add(4'hA, 0, 2'd2, 4'b1010, 0);
      add(4'hA, 0, 2'd1, 4'b0000, 1);
      add(4'hA, 0, 2'd1, 4'b0000, 1);
      add(4'hA, 0, 2'd1, 4'b0000, 1);
      add(4'hA, 0, 2'd1, 4'b0000, 1);
      add(4'hA, 0, 2'd2, 4'b0101, 0);
      add(4'hA, 1, 2'd3, 4'b0000, 0);
      add(4'h0, 0, 2'd3, 4'b0000, 0);
      add(4'h0, 0, 2'd3, 4'b0000, 0);
      add(4'h0, 0, 2'd3, 4'b0000, 0);
      add(4'hF, 0, 2'd3, 4'b0000, 0);
      add(4'hF, 0, 2'd0, 4'b0000, 0);
      add(4'hF, 1, 2'd3, 4'b0000, 0);
      add(4'hF, 0, 2'd0, 4'b0000, 0);
      add(4'h0, 0, 2'd0, 4'b0000, 0);
      add(4'h0, 0, 2'd1, 4'b0000, 1);
      add(4'h0, 0, 2'd1, 4'b0000, 1);
      add(4'h0, 0, 2'd1, 4'b0000, 1);
      add(4'h0, 0, 2'd1, 4'b0000, 1);
      add(4'h0, 1, 2'd3, 4'b0000, 0);
      add(4'hF, 0, 2'd3, 4'b0000, 0);
      add(4'hF, 0, 2'd0, 4'b0000, 0);
      foreach (vecs[i]) begin
         cycle(vecs[i].dir, vecs[i].es);
         chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
         chk($sformatf("vec%0d_bridge", i), int'(bridge()), int'(vecs[i].br));
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].bz));
      end

      // Half speed on both motors: 5 of every 10 cycles high, in2 low
      run_until(2'd2, 4'b0101, 20, "half_enter_drive");
      hi_l = 0; hi_r = 0; hi_2 = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(4'b0101, 1'b0);
         hi_l += int'(l_in1);
         hi_r += int'(r_in1);
         hi_2 += int'(l_in2 | r_in2);
      end
      chk("half_l_high_count", hi_l, 10);
      chk("half_r_high_count", hi_r, 10);
      chk("half_in2_high_count", hi_2, 0);
      fall_before = last_fall;
      last_fall = -1;
      cycle(4'b0001, 1'b0);
      run_until(2'd2, 4'b0001, 20, "half_reenter_drive");
      for (int i = 0; i < 12; i++) cycle(4'b0001, 1'b0);
      chk("pwm_fall_seen", int'(last_fall > 0 && fall_before > 0), 1);
      chk("pwm_phase_kept", (last_fall - fall_before) % PP, 0);

      // Second change while DEAD at count 2 restarts the dead interval
      run_until(2'd1, 4'b1010, 5, "restart_enter_dead");
      cycle(4'b1010, 1'b0);
      cycle(4'b1010, 1'b0);
      nd = 0;
      cycle(4'b1000, 1'b0);
      while (state == 2'd1 && nd < 20) begin
         nd++;
         cycle(4'b1000, 1'b0);
      end
      chk("restart_dead_samples", nd + 1, 6);
      chk("restart_state", int'(state), 2);
      chk("restart_bridge", int'(bridge()), int'(4'b0110));

      // Reset pulse in the middle of a dead interval
      run_until(2'd1, 4'b0000, 5, "rst_enter_dead");
      cycle(4'b0000, 1'b0);
      pulse_reset("rst_mid_dead");
      cycle(4'b0000, 1'b0);
      chk("rst_resume_idle", int'(state), 0);
      cycle(4'b0000, 1'b0);

      // Random commands held for random durations, rare estop and reset
      for (int seg = 0; seg < 250; seg++) begin
         logic [3:0] d;
         int hold;
         d = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         hold = $urandom_range(1, 9);
         for (int k = 0; k < hold; k++)
            cycle(d, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
         if ($urandom_range(0, 59) == 0) pulse_reset("rand_rst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
